// File: rtl/digests_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : digests_responder_if
//  Brief    : Request / header / payload-beat bundle between the request
//             decoder, the DIGESTS responder and the transmit framer.
//  Revision : 1.0 - initial release
// ============================================================================
interface digests_responder_if #(
   parameter int NUM_SLOTS = 8,
   parameter int BUS_BYTES = 4
);
   logic                     req_valid;
   logic                     req_ready;
   logic [NUM_SLOTS-1:0]     slot_mask;
   logic [31:0]              header;
   logic                     hdr_valid;
   logic [8*BUS_BYTES-1:0]   out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic                     out_last;
   logic                     rsp_done;

   // Requester / consumer side (decoder + framer)
   modport master (
      output req_valid, slot_mask, out_ready,
      input  req_ready, header, hdr_valid, out_data, out_valid, out_last, rsp_done
   );

   // Responder side
   modport slave (
      input  req_valid, slot_mask, out_ready,
      output req_ready, header, hdr_valid, out_data, out_valid, out_last, rsp_done
   );
endinterface
`default_nettype wire

// File: rtl/digests_responder.sv
`default_nettype none
// ============================================================================
//  Module   : digests_responder
//  Brief    : GET_DIGESTS response generator. Stores one digest per
//             certificate slot, emits the response header and then streams
//             the digests of every provisioned slot in ascending order.
//             Optional feature macro: DIGESTS_ERROR_RESP_EN (an empty slot
//             mask produces an ERROR/InvalidRequest header instead).
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef PROTOCOL_VERSION
`define PROTOCOL_VERSION 8'h12
`endif
`ifndef DIGESTS_ANSWER_CMD
`define DIGESTS_ANSWER_CMD 8'h01
`endif

module digests_responder #(
   parameter int  NUM_SLOTS    = 8,     // 1..8
   parameter int  DIGEST_BYTES = 32,    // multiple of BUS_BYTES
   parameter int  BUS_BYTES    = 4,
   localparam int WPD          = DIGEST_BYTES / BUS_BYTES,
   localparam int SLOT_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
   localparam int WORD_W       = (WPD > 1) ? $clog2(WPD) : 1,
   localparam int DATA_W       = 8 * BUS_BYTES
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   digests_responder_if.slave     bus,
   input  wire logic              dg_wr_en_i,
   input  wire logic [SLOT_W-1:0] dg_wr_slot_i,
   input  wire logic [WORD_W-1:0] dg_wr_word_i,
   input  wire logic [DATA_W-1:0] dg_wr_data_i,
   output logic                   dg_wr_drop_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HDR  = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [7:0] C_VERSION = `PROTOCOL_VERSION;
   localparam logic [7:0] C_CMD     = `DIGESTS_ANSWER_CMD;

   logic [1:0]           state_q, state_d;
   logic [NUM_SLOTS-1:0] mask_q, mask_d;
   logic [SLOT_W-1:0]    slot_q, slot_d;
   logic [WORD_W-1:0]    word_q, word_d;
   logic [31:0]          header_q, header_d;

   // Digest storage; deliberately not reset (contents undefined until written)
   logic [DATA_W-1:0]    mem_q [NUM_SLOTS][WPD];

   logic [SLOT_W-1:0]    first_slot;
   logic [SLOT_W-1:0]    next_slot;
   logic                 next_found;
   logic                 last_word;
   logic [7:0]           mask8;
   logic                 wr_in_range;
   logic                 wr_accept;

   assign mask8     = 8'(bus.slot_mask);
   assign last_word = (word_q == WORD_W'(WPD - 1));

   // Lowest provisioned slot: the first digest of the response
   always_comb begin
      first_slot = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (mask_q[i]) first_slot = SLOT_W'(i);
      end
   end

   // Next provisioned slot above the current one, so slots chain without a bubble
   always_comb begin
      next_slot  = '0;
      next_found = 1'b0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (mask_q[i] && (i > int'(slot_q))) begin
            next_slot  = SLOT_W'(i);
            next_found = 1'b1;
         end
      end
   end

   // Response sequencer next-state logic
   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      slot_d   = slot_q;
      word_d   = word_q;
      header_d = header_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               state_d  = S_HDR;
               mask_d   = bus.slot_mask;
               // Header is captured here and held stable until the next request
               header_d = {C_VERSION, C_CMD, 8'h00, mask8};
`ifdef DIGESTS_ERROR_RESP_EN
               if (bus.slot_mask == '0) header_d = {C_VERSION, 8'h7F, 8'h01, 8'h00};
`endif
            end
         end
         S_HDR: begin
            if (mask_q != '0) begin
               state_d = S_SEND;
               slot_d  = first_slot;
               word_d  = '0;
            end else begin
               state_d = S_DONE;
            end
         end
         S_SEND: begin
            if (bus.out_ready) begin
               if (last_word) begin
                  word_d = '0;
                  if (next_found) slot_d  = next_slot;
                  else            state_d = S_DONE;
               end else begin
                  word_d = word_q + 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         mask_q   <= '0;
         slot_q   <= '0;
         word_q   <= '0;
         header_q <= '0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         slot_q   <= slot_d;
         word_q   <= word_d;
         header_q <= header_d;
      end
   end

   // Writes land only while idle and in range; anything else is flagged as dropped
   assign wr_in_range  = (int'(dg_wr_slot_i) < NUM_SLOTS) && (int'(dg_wr_word_i) < WPD);
   assign wr_accept    = dg_wr_en_i && (state_q == S_IDLE) && wr_in_range;
   assign dg_wr_drop_o = dg_wr_en_i && !wr_accept;

   // Digest storage write port
   always_ff @(posedge clk) begin
      if (wr_accept) mem_q[dg_wr_slot_i][dg_wr_word_i] <= dg_wr_data_i;
   end

   // Outputs decode straight from state so an async reset clears them at once
   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.hdr_valid = (state_q == S_HDR);
   assign bus.header    = header_q;
   assign bus.out_valid = (state_q == S_SEND);
   assign bus.out_data  = (state_q == S_SEND) ? mem_q[slot_q][word_q] : '0;
   assign bus.out_last  = (state_q == S_SEND) && last_word && !next_found;
   assign bus.rsp_done  = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_digests_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_digests_responder
//  Brief    : Directed self-checking bench for digests_responder.
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef PROTOCOL_VERSION
`define PROTOCOL_VERSION 8'h12
`endif
`ifndef DIGESTS_ANSWER_CMD
`define DIGESTS_ANSWER_CMD 8'h01
`endif

module tb_digests_responder;

   localparam logic [7:0] VER = `PROTOCOL_VERSION;
   localparam logic [7:0] CMD = `DIGESTS_ANSWER_CMD;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Main DUT: default parameters
   digests_responder_if #(.NUM_SLOTS(8), .BUS_BYTES(4)) bus ();
   logic        wr_en;
   logic [2:0]  wr_slot;
   logic [2:0]  wr_word;
   logic [31:0] wr_data;
   logic        wr_drop;

   digests_responder #(.NUM_SLOTS(8), .DIGEST_BYTES(32), .BUS_BYTES(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .dg_wr_en_i   (wr_en),
      .dg_wr_slot_i (wr_slot),
      .dg_wr_word_i (wr_word),
      .dg_wr_data_i (wr_data),
      .dg_wr_drop_o (wr_drop)
   );

   // Small DUT: 3 slots x 3 words, so out-of-range indices are representable
   digests_responder_if #(.NUM_SLOTS(3), .BUS_BYTES(4)) sbus ();
   logic        s_wr_en;
   logic [1:0]  s_wr_slot;
   logic [1:0]  s_wr_word;
   logic [31:0] s_wr_data;
   logic        s_wr_drop;

   digests_responder #(.NUM_SLOTS(3), .DIGEST_BYTES(12), .BUS_BYTES(4)) dut_s (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (sbus),
      .dg_wr_en_i   (s_wr_en),
      .dg_wr_slot_i (s_wr_slot),
      .dg_wr_word_i (s_wr_word),
      .dg_wr_data_i (s_wr_data),
      .dg_wr_drop_o (s_wr_drop)
   );

   int n_vec = 0;
   int n_err = 0;

   // Capture of one response on the main DUT
   logic [31:0] cap_data [64];
   logic        cap_last [64];
   int          cap_cyc  [64];
   int          n_beats;
   int          done_cyc;
   bit          done_seen;
   bit          stall_bad;
   bit          any_valid;
   logic [31:0] hdr_cap;
   logic        hdr_v_cap;
   logic        rr_at_done;

   task automatic wr(input logic [2:0] s, input logic [2:0] w, input logic [31:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_slot = s; wr_word = w; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Issue one request and record header, accepted beats and completion timing.
   // Cycle c=0 is the cycle two clocks after request acceptance.
   task automatic run_rsp(input logic [7:0] mask, input bit stall);
      logic [31:0] prev_data;
      bit          prev_pending;
      n_beats = 0; done_seen = 0; stall_bad = 0; any_valid = 0; done_cyc = -1;
      prev_pending = 0; prev_data = '0; rr_at_done = 1'bx;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.slot_mask = mask; bus.out_ready = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      hdr_cap = bus.header; hdr_v_cap = bus.hdr_valid;
      for (int c = 0; c < 300 && !done_seen; c++) begin
         @(negedge clk);
         bus.out_ready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
         if (bus.out_valid) begin
            any_valid = 1;
            if (prev_pending && (bus.out_data !== prev_data)) stall_bad = 1;
            if (bus.out_ready) begin
               if (n_beats < 64) begin
                  cap_data[n_beats] = bus.out_data;
                  cap_last[n_beats] = bus.out_last;
                  cap_cyc[n_beats]  = c;
               end
               n_beats++;
               prev_pending = 0;
            end else begin
               prev_pending = 1;
               prev_data    = bus.out_data;
            end
         end
         if (bus.rsp_done) begin
            done_seen = 1; done_cyc = c; rr_at_done = bus.req_ready;
         end
      end
      bus.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b exp 1", bus.req_ready); end
      n_vec++; if (bus.header !== 32'h0) begin n_err++; $display("FAIL reset_header: got %h exp 00000000", bus.header); end
      n_vec++; if ({bus.hdr_valid, bus.out_valid, bus.out_last, bus.rsp_done, wr_drop} !== 5'b0) begin
         n_err++; $display("FAIL reset_strobes: got %b exp 00000", {bus.hdr_valid, bus.out_valid, bus.out_last, bus.rsp_done, wr_drop}); end
      n_vec++; if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h exp 00000000", bus.out_data); end
      rst_n = 1'b1;
   endtask

   task automatic test_single_slot();
      for (int w = 0; w < 8; w++) wr(3'd0, 3'(w), 32'(w));
      run_rsp(8'h01, 1'b0);
      n_vec++; if (hdr_v_cap !== 1'b1) begin n_err++; $display("FAIL single_hdr_valid: got %b exp 1", hdr_v_cap); end
      n_vec++; if (hdr_cap !== {VER, CMD, 8'h00, 8'h01}) begin n_err++; $display("FAIL single_header: got %h exp %h", hdr_cap, {VER, CMD, 8'h00, 8'h01}); end
      n_vec++; if (n_beats !== 8) begin n_err++; $display("FAIL single_beats: got %0d exp 8", n_beats); end
      for (int i = 0; i < 8 && i < n_beats; i++) begin
         n_vec++; if (cap_data[i] !== 32'(i) || cap_cyc[i] !== i || cap_last[i] !== (i == 7)) begin
            n_err++; $display("FAIL single_beat%0d: got data %h cyc %0d last %b exp data %h cyc %0d last %b",
                              i, cap_data[i], cap_cyc[i], cap_last[i], 32'(i), i, (i == 7)); end
      end
      n_vec++; if (done_cyc !== 8) begin n_err++; $display("FAIL single_done_cycle: got %0d exp 8", done_cyc); end
      n_vec++; if (rr_at_done !== 1'b0) begin n_err++; $display("FAIL single_ready_at_done: got %b exp 0", rr_at_done); end
      @(negedge clk);
      n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL single_ready_after: got %b exp 1", bus.req_ready); end
   endtask

   task automatic test_multi_slot();
      logic [31:0] exp_d;
      int          sl;
      for (int w = 0; w < 8; w++) begin
         wr(3'd2, 3'(w), 32'h20 + 32'(w));
         wr(3'd5, 3'(w), 32'h50 + 32'(w));
         wr(3'd7, 3'(w), 32'h70 + 32'(w));
      end
      run_rsp(8'hA4, 1'b0);
      n_vec++; if (hdr_cap !== {VER, CMD, 8'h00, 8'hA4}) begin n_err++; $display("FAIL multi_header: got %h exp %h", hdr_cap, {VER, CMD, 8'h00, 8'hA4}); end
      n_vec++; if (n_beats !== 24) begin n_err++; $display("FAIL multi_beats: got %0d exp 24", n_beats); end
      for (int i = 0; i < 24 && i < n_beats; i++) begin
         sl    = (i < 8) ? 2 : (i < 16) ? 5 : 7;
         exp_d = 32'(sl * 16 + (i % 8));
         n_vec++; if (cap_data[i] !== exp_d || cap_cyc[i] !== i || cap_last[i] !== (i == 23)) begin
            n_err++; $display("FAIL multi_beat%0d: got data %h cyc %0d last %b exp data %h cyc %0d last %b",
                              i, cap_data[i], cap_cyc[i], cap_last[i], exp_d, i, (i == 23)); end
      end
      n_vec++; if (done_cyc !== 24) begin n_err++; $display("FAIL multi_done_cycle: got %0d exp 24", done_cyc); end
   endtask

   task automatic test_backpressure();
      run_rsp(8'h01, 1'b1);
      n_vec++; if (n_beats !== 8) begin n_err++; $display("FAIL stall_beats: got %0d exp 8", n_beats); end
      n_vec++; if (stall_bad !== 1'b0) begin n_err++; $display("FAIL stall_hold: got unstable=%b exp 0", stall_bad); end
      for (int i = 0; i < 8 && i < n_beats; i++) begin
         n_vec++; if (cap_data[i] !== 32'(i)) begin n_err++; $display("FAIL stall_beat%0d: got %h exp %h", i, cap_data[i], 32'(i)); end
      end
      n_vec++; if (cap_last[7] !== 1'b1) begin n_err++; $display("FAIL stall_last: got %b exp 1", cap_last[7]); end
      n_vec++; if (done_cyc !== 16) begin n_err++; $display("FAIL stall_done_cycle: got %0d exp 16", done_cyc); end
   endtask

   task automatic test_empty_mask();
      logic [31:0] exp_h;
`ifdef DIGESTS_ERROR_RESP_EN
      exp_h = {VER, 8'h7F, 8'h01, 8'h00};
`else
      exp_h = {VER, CMD, 8'h00, 8'h00};
`endif
      run_rsp(8'h00, 1'b0);
      n_vec++; if (hdr_v_cap !== 1'b1 || hdr_cap !== exp_h) begin n_err++; $display("FAIL empty_header: got %h (valid %b) exp %h (valid 1)", hdr_cap, hdr_v_cap, exp_h); end
      n_vec++; if (any_valid !== 1'b0) begin n_err++; $display("FAIL empty_no_beats: got out_valid seen=%b exp 0", any_valid); end
      n_vec++; if (done_cyc !== 0) begin n_err++; $display("FAIL empty_done_cycle: got %0d exp 0", done_cyc); end
      @(negedge clk);
      n_vec++; if (bus.header !== exp_h) begin n_err++; $display("FAIL empty_header_held: got %h exp %h", bus.header, exp_h); end
   endtask

   task automatic test_write_drop();
      // Legal idle write (same value) is not dropped
      @(negedge clk);
      wr_en = 1'b1; wr_slot = 3'd0; wr_word = 3'd0; wr_data = 32'h0;
      #1;
      n_vec++; if (wr_drop !== 1'b0) begin n_err++; $display("FAIL drop_idle_write: got %b exp 0", wr_drop); end
      @(negedge clk);
      wr_en = 1'b0;
      // Write while streaming is discarded
      bus.req_valid = 1'b1; bus.slot_mask = 8'h01; bus.out_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL drop_in_send: got out_valid %b exp 1", bus.out_valid); end
      wr_en = 1'b1; wr_slot = 3'd0; wr_word = 3'd0; wr_data = 32'hDEADBEEF;
      #1;
      n_vec++; if (wr_drop !== 1'b1) begin n_err++; $display("FAIL drop_send_write: got %b exp 1", wr_drop); end
      @(negedge clk);
      wr_en = 1'b0; bus.out_ready = 1'b1;
      for (int c = 0; c < 40 && bus.rsp_done !== 1'b1; c++) @(negedge clk);
      n_vec++; if (bus.rsp_done !== 1'b1) begin n_err++; $display("FAIL drop_rsp_timeout: got rsp_done %b exp 1", bus.rsp_done); end
      run_rsp(8'h01, 1'b0);
      n_vec++; if (n_beats !== 8 || cap_data[0] !== 32'h0 || cap_data[7] !== 32'h7) begin
         n_err++; $display("FAIL drop_storage_kept: got beats %0d w0 %h w7 %h exp 8 00000000 00000007", n_beats, cap_data[0], cap_data[7]); end
   endtask

   task automatic test_write_range();
      for (int w = 0; w < 3; w++) begin
         @(negedge clk);
         s_wr_en = 1'b1; s_wr_slot = 2'd1; s_wr_word = 2'(w); s_wr_data = 32'h100 + 32'(w);
         #1;
         n_vec++; if (s_wr_drop !== 1'b0) begin n_err++; $display("FAIL range_legal_w%0d: got drop %b exp 0", w, s_wr_drop); end
      end
      @(negedge clk);
      s_wr_slot = 2'd1; s_wr_word = 2'd3; s_wr_data = 32'hFFFF_FFFF;
      #1;
      n_vec++; if (s_wr_drop !== 1'b1) begin n_err++; $display("FAIL range_word_eq_wpd: got drop %b exp 1", s_wr_drop); end
      @(negedge clk);
      s_wr_slot = 2'd3; s_wr_word = 2'd0;
      #1;
      n_vec++; if (s_wr_drop !== 1'b1) begin n_err++; $display("FAIL range_slot_eq_num: got drop %b exp 1", s_wr_drop); end
      @(negedge clk);
      s_wr_en = 1'b0;
      sbus.req_valid = 1'b1; sbus.slot_mask = 3'b010; sbus.out_ready = 1'b1;
      @(negedge clk);
      sbus.req_valid = 1'b0;
      n_vec++; if (sbus.header !== {VER, CMD, 8'h00, 8'h02}) begin n_err++; $display("FAIL range_header: got %h exp %h", sbus.header, {VER, CMD, 8'h00, 8'h02}); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++; if (sbus.out_valid !== 1'b1 || sbus.out_data !== 32'h100 + 32'(i) || sbus.out_last !== (i == 2)) begin
            n_err++; $display("FAIL range_beat%0d: got valid %b data %h last %b exp 1 %h %b",
                              i, sbus.out_valid, sbus.out_data, sbus.out_last, 32'h100 + 32'(i), (i == 2)); end
      end
      @(negedge clk);
      n_vec++; if (sbus.rsp_done !== 1'b1) begin n_err++; $display("FAIL range_done: got %b exp 1", sbus.rsp_done); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.req_valid = 1'b1; bus.slot_mask = 8'h01; bus.out_ready = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (4) @(negedge clk);
      n_vec++; if (bus.out_data !== 32'h3) begin n_err++; $display("FAIL midrst_pre_beat: got %h exp 00000003", bus.out_data); end
      rst_n = 1'b0;
      #1;
      n_vec++; if (bus.req_ready !== 1'b1 || bus.header !== 32'h0) begin n_err++; $display("FAIL midrst_ready_header: got %b %h exp 1 00000000", bus.req_ready, bus.header); end
      n_vec++; if ({bus.hdr_valid, bus.out_valid, bus.out_last, bus.rsp_done} !== 4'b0 || bus.out_data !== 32'h0) begin
         n_err++; $display("FAIL midrst_outputs: got strobes %b data %h exp 0000 00000000",
                           {bus.hdr_valid, bus.out_valid, bus.out_last, bus.rsp_done}, bus.out_data); end
      @(negedge clk);
      rst_n = 1'b1;
      run_rsp(8'h01, 1'b0);
      n_vec++; if (n_beats !== 8 || cap_data[0] !== 32'h0 || cap_data[7] !== 32'h7 || done_cyc !== 8) begin
         n_err++; $display("FAIL midrst_rerun: got beats %0d w0 %h w7 %h done %0d exp 8 00000000 00000007 8",
                           n_beats, cap_data[0], cap_data[7], done_cyc); end
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.slot_mask = '0; bus.out_ready = 1'b1;
      sbus.req_valid = 1'b0; sbus.slot_mask = '0; sbus.out_ready = 1'b1;
      wr_en = 1'b0; wr_slot = '0; wr_word = '0; wr_data = '0;
      s_wr_en = 1'b0; s_wr_slot = '0; s_wr_word = '0; s_wr_data = '0;
      test_reset();
      test_single_slot();
      test_multi_slot();
      test_backpressure();
      test_empty_mask();
      test_write_drop();
      test_write_range();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, vectors %0d", n_vec);
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/digests_responder.md
# digests_responder

Parametrised DIGESTS response generator for the authentication responder path. Holds one digest per provisioned certificate slot in local storage, loaded through a word-wide write port. On a GET_DIGESTS request it emits the 4-byte response header, then streams the digests of every provisioned slot in ascending slot order over a valid/ready beat interface. It sits between the request decoder and the message transmit framer.

## Interface
- NUM_SLOTS, 8: number of certificate slots; range 1..8.
- DIGEST_BYTES, 32: bytes per digest; must be a multiple of BUS_BYTES.
- BUS_BYTES, 4: payload beat width in bytes; WPD = DIGEST_BYTES/BUS_BYTES words per digest.
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  GET_DIGESTS request strobe.
- req_ready  out  1  high only in IDLE.
- slot_mask  in  NUM_SLOTS  provisioned slots; sampled on request acceptance.
- dg_wr_en  in  1  digest storage write strobe.
- dg_wr_slot  in  clog2(NUM_SLOTS) (min 1)  slot index of the write.
- dg_wr_word  in  clog2(WPD) (min 1)  word index within the digest.
- dg_wr_data  in  8*BUS_BYTES  write data.
- dg_wr_drop  out  1  one-cycle pulse when a write is discarded.
- header  out  32  response header {version, cmd, param1, param2}.
- hdr_valid  out  1  one-cycle pulse; header is held stable until the next request.
- out_data  out  8*BUS_BYTES  payload beat; the first byte on the wire is the MSB.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  marks the final beat of the response.
- rsp_done  out  1  one-cycle pulse when the response completes.

## Operation
- States: IDLE, HDR, SEND, DONE.
- IDLE: req_ready=1. When req_valid=1, latch slot_mask into mask_q, compute first = lowest set bit of mask_q, and go to HDR.
- HDR, one cycle: drive header = {`PROTOCOL_VERSION, `DIGESTS_ANSWER_CMD, 8'h00, mask_q zero-extended to 8 bits} and pulse hdr_valid.
  - mask_q != 0: go to SEND with slot=first, word=0.
  - mask_q == 0: go to DONE (see Configuration).
- SEND: out_data = storage[slot][word]; out_valid=1.
  - On out_valid && out_ready, advance word.
  - When word==WPD-1, jump to the next set slot above the current one (combinational priority search, no bubble) and reset word to 0.
  - out_last=1 on word WPD-1 of the highest set slot; its acceptance goes to DONE.
- DONE, one cycle: pulse rsp_done, then go to IDLE.
- out_data/out_valid hold while out_ready=0; no beat is ever dropped or repeated.
- Storage write: accepted only in IDLE. A write in any other state is discarded and pulses dg_wr_drop. A write out of range (slot ≥ NUM_SLOTS or word ≥ WPD) is also discarded and pulses dg_wr_drop.
- A write in the same cycle as request acceptance takes effect and is visible in that response.
- req_valid outside IDLE is ignored; no queueing.

## Timing
- Reset values: req_ready=1, header=0, hdr_valid=0, out_valid=0, out_last=0, out_data=0, rsp_done=0, dg_wr_drop=0. Storage contents are not reset and read as undefined until written.
- Request accepted at edge n: hdr_valid=1 during cycle n+1, first out_valid during cycle n+2.
- With out_ready held at 1: k set slots produce k*WPD consecutive beats, rsp_done one cycle after the last beat, req_ready back one cycle after that.
- Reset mid-response: returns immediately to IDLE with all outputs at their reset values; a partial response is not resumed.

## Configuration
- DIGESTS_ERROR_RESP_EN defined: mask_q==0 makes HDR emit an error header {`PROTOCOL_VERSION, 8'h7F, 8'h01, 8'h00} (ERROR, InvalidRequest) instead of a DIGESTS header, then DONE. No payload beats.
- Not defined: mask_q==0 emits the DIGESTS header with param2=0x00, then DONE. No payload beats.

## Test plan
- Defaults; write slot 0 words 0..7 = 32'h00000000..32'h00000007; mask 8'h01; out_ready=1 -> header param2=0x01, 8 beats 0..7 on consecutive cycles, out_last on beat 7, rsp_done one cycle later.
- Mask 8'hA4; slots 2/5/7 filled with word values 0x2w/0x5w/0x7w -> 24 beats in order slot 2, 5, 7, no gaps between slots, out_last only on slot 7 word 7.
- Mask 8'h01; toggle out_ready 1,0,0,1 repeating -> out_data stable while stalled, exactly 8 beats accepted, no duplicates.
- Mask 8'h00 -> with DIGESTS_ERROR_RESP_EN, header 32'h{ver}7F0100; without it, header cmd=DIGESTS, param2=0x00; in both cases out_valid never asserts and rsp_done pulses.
- dg_wr_en during SEND, and a write with dg_wr_word=WPD -> dg_wr_drop pulses, storage unchanged, next response returns the original data.
- rst_n low after 3 of 8 beats -> outputs at reset values within the same cycle; a new request afterwards returns the full 8 beats.
